// File: rtl/beam_sweep_ctrl.sv
// Beam steering sweep controller: steps four mic delays across all angles,
// integrates |beam| per angle and reports the strongest angle.
module beam_sweep_ctrl #(
  parameter int NUM_ANGLES     = 15,
  parameter int STEP_US        = 2,
  parameter int BITS_AUDIO     = 24,
  parameter int SETTLE_SAMPLES = 64,
  parameter int DWELL_SAMPLES  = 1024
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [5:0]                   manual_angle_in,
  input  logic signed [BITS_AUDIO-1:0] beam_audio_in,
  input  logic                         beam_valid_in,
  output logic [7:0]                   delay_1_out,
  output logic [7:0]                   delay_2_out,
  output logic [7:0]                   delay_3_out,
  output logic [7:0]                   delay_4_out,
  output logic [5:0]                   cur_angle_out,
  output logic [5:0]                   best_angle_out,
  output logic [47:0]                  best_energy_out,
  output logic                         busy_out,
  output logic                         done_out
);
  localparam int HALF = (NUM_ANGLES - 1) / 2;
  localparam int CMAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = BITS_AUDIO + 1;
  localparam logic [5:0] LAST = 6'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, MEASURE, COMPARE, DONE} state_t;
  state_t state, state_nx;

  logic [3:0][7:0] delay;
  logic [5:0]      cur_angle, max_a, best_a, manual_q, man_clamp;
  logic [47:0]     acc, max_e, best_e, acc_nx;
  logic [CW-1:0]   cnt;
  logic            armed, track, ret_idle, man_move;
  logic [AW-1:0]   ext, mag;
  logic [48:0]     sum;

  function automatic logic [7:0] dly(input logic [5:0] a, input int k);
    int o, v;
    o = int'(a) - HALF;
    if (o >= 0) v = (k - 1) * o * STEP_US;
    else        v = (4 - k) * (-o) * STEP_US;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  // sign-extend one bit so |most negative| fits
  assign ext    = {beam_audio_in[BITS_AUDIO-1], beam_audio_in};
  assign mag    = ext[AW-1] ? (~ext) + AW'(1) : ext;
  assign sum    = {1'b0, acc} + 49'(mag);
  assign acc_nx = sum[48] ? '1 : sum[47:0];

  assign man_clamp = (manual_angle_in > LAST) ? LAST : manual_angle_in;
  // after a sweep the best angle is held until the manual input moves
  assign man_move  = armed && (track || (manual_angle_in != manual_q)) && (man_clamp != cur_angle);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_out = 1'b0;
    done_out = 1'b0;
    case (state)
      IDLE:    if ((armed && start_in) || man_move) state_nx = APPLY;
      APPLY: begin
        busy_out = 1'b1;
        state_nx = ret_idle ? IDLE : SETTLE;
      end
      SETTLE: begin
        busy_out = 1'b1;
        if (beam_valid_in && cnt == CW'(SETTLE_SAMPLES - 1)) state_nx = MEASURE;
      end
      MEASURE: begin
        busy_out = 1'b1;
        if (beam_valid_in && cnt == CW'(DWELL_SAMPLES - 1)) state_nx = COMPARE;
      end
      COMPARE: begin
        busy_out = 1'b1;
        state_nx = (cur_angle == LAST) ? DONE : APPLY;
      end
      DONE: begin
        done_out = 1'b1;
        state_nx = APPLY;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      delay     <= '0;
      cur_angle <= '0;
      max_a     <= '0;
      max_e     <= '0;
      best_a    <= '0;
      best_e    <= '0;
      acc       <= '0;
      cnt       <= '0;
      manual_q  <= '0;
      armed     <= 1'b0;
      track     <= 1'b1;
      ret_idle  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      manual_q <= manual_angle_in;
      case (state)
        IDLE: begin
          if (manual_angle_in != manual_q) track <= 1'b1;
          if (armed && start_in) begin
            cur_angle <= '0;
            acc       <= '0;
            ret_idle  <= 1'b0;
          end else if (man_move) begin
            cur_angle <= man_clamp;
            ret_idle  <= 1'b1;
          end
        end
        APPLY: begin
          for (int k = 0; k < 4; k++) delay[k] <= dly(cur_angle, k + 1);
          cnt <= '0;
        end
        SETTLE: if (beam_valid_in)
          cnt <= (cnt == CW'(SETTLE_SAMPLES - 1)) ? '0 : cnt + CW'(1);
        MEASURE: if (beam_valid_in) begin
          acc <= acc_nx;
          cnt <= (cnt == CW'(DWELL_SAMPLES - 1)) ? '0 : cnt + CW'(1);
        end
        COMPARE: begin
          // strict compare: ties keep the earlier (lower) angle
          if (cur_angle == '0 || acc > max_e) begin
            max_a <= cur_angle;
            max_e <= acc;
          end
          acc <= '0;
          if (cur_angle != LAST) cur_angle <= cur_angle + 6'd1;
        end
        DONE: begin
          best_a    <= max_a;
          best_e    <= max_e;
          cur_angle <= max_a;
          ret_idle  <= 1'b1;
          track     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign delay_1_out     = delay[0];
  assign delay_2_out     = delay[1];
  assign delay_3_out     = delay[2];
  assign delay_4_out     = delay[3];
  assign cur_angle_out   = cur_angle;
  assign best_angle_out  = best_a;
  assign best_energy_out = best_e;
endmodule

// File: tb/tb_beam_sweep_ctrl.sv
// Directed bench for beam_sweep_ctrl: manual delay mapping, sweeps, tie rule,
// stalls, ignored start, mid-sweep reset, plus a saturating-step instance.
module tb_beam_sweep_ctrl;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [5:0]         manual = '0;
  logic signed [23:0] audio = '0;
  logic               valid = 1'b0;
  logic [7:0]         d1, d2, d3, d4, s1, s2, s3, s4;
  logic [5:0]         cur, best_a, s_cur, s_best_a;
  logic [47:0]        best_e, s_best_e;
  logic               busy, done, s_busy, s_done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  beam_sweep_ctrl #(.NUM_ANGLES(15), .STEP_US(2), .BITS_AUDIO(24),
                    .SETTLE_SAMPLES(4), .DWELL_SAMPLES(8)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .manual_angle_in(manual),
    .beam_audio_in(audio), .beam_valid_in(valid),
    .delay_1_out(d1), .delay_2_out(d2), .delay_3_out(d3), .delay_4_out(d4),
    .cur_angle_out(cur), .best_angle_out(best_a), .best_energy_out(best_e),
    .busy_out(busy), .done_out(done));

  beam_sweep_ctrl #(.NUM_ANGLES(15), .STEP_US(40), .BITS_AUDIO(24),
                    .SETTLE_SAMPLES(4), .DWELL_SAMPLES(8)) dut_s (
    .clk_in(clk), .rst_in(rst), .start_in(1'b0), .manual_angle_in(manual),
    .beam_audio_in(audio), .beam_valid_in(valid),
    .delay_1_out(s1), .delay_2_out(s2), .delay_3_out(s3), .delay_4_out(s4),
    .cur_angle_out(s_cur), .best_angle_out(s_best_a), .best_energy_out(s_best_e),
    .busy_out(s_busy), .done_out(s_done));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_dly(input string tag, input int e1, input int e2, input int e3, input int e4);
    chk({tag, ".d1"}, 64'(d1), 64'(e1));
    chk({tag, ".d2"}, 64'(d2), 64'(e2));
    chk({tag, ".d3"}, 64'(d3), 64'(e3));
    chk({tag, ".d4"}, 64'(d4), 64'(e4));
  endtask

  // pat 1: +1000 only at angle 9; pat 2: most negative sample everywhere
  task automatic sweep(input string tag, input int pat, input bit tog, input int start_at);
    int dones = 0;
    int extra = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      valid = tog ? c[0] : 1'b1;
      if (pat == 1) audio = (cur == 6'd9) ? 24'sd1000 : 24'sd0;
      else          audio = 24'sh800000;
      start = (c == start_at);
      step();
      if (c == 10) chk({tag, ".busy"}, 64'(busy), 64'd1);
      if (done) begin
        dones++;
        if (extra < 0) extra = 4;
      end
      if (extra > 0) extra--;
      else if (extra == 0) break;
    end
    start = 1'b0;
    valid = 1'b0;
    audio = '0;
    chk({tag, ".done_cnt"}, 64'(dones), 64'd1);
  endtask

  initial begin
    step(3);
    chk_dly("rst", 0, 0, 0, 0);
    chk("rst.cur", 64'(cur), 64'd0);
    chk("rst.best_a", 64'(best_a), 64'd0);
    chk("rst.best_e", 64'(best_e), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);

    rst = 1'b1;
    manual = 6'd10;
    step(5);
    chk("man10.cur", 64'(cur), 64'd10);
    chk_dly("man10", 0, 6, 12, 18);
    manual = 6'd4;
    step(5);
    chk_dly("man4", 18, 12, 6, 0);
    manual = 6'd14;
    step(5);
    chk_dly("man14", 0, 14, 28, 42);
    chk("sat.d1", 64'(s1), 64'd0);
    chk("sat.d2", 64'(s2), 64'd255);
    chk("sat.d4", 64'(s4), 64'd255);
    manual = 6'd4;
    step(5);
    manual = 6'd40;
    step(5);
    chk("clamp.cur", 64'(cur), 64'd14);

    sweep("sw9", 1, 1'b0, -1);
    chk("sw9.best_a", 64'(best_a), 64'd9);
    chk("sw9.best_e", 64'(best_e), 64'd8000);
    chk("sw9.cur", 64'(cur), 64'd9);
    chk_dly("sw9", 0, 4, 8, 12);
    chk("sw9.busy", 64'(busy), 64'd0);
    step(5);
    chk("hold.cur", 64'(cur), 64'd9);
    manual = 6'd4;
    step(5);
    chk("track.cur", 64'(cur), 64'd4);

    sweep("neg", 2, 1'b0, -1);
    chk("neg.best_a", 64'(best_a), 64'd0);
    chk("neg.best_e", 64'(best_e), 64'd67108864);
    chk_dly("neg", 42, 28, 14, 0);

    sweep("tog", 1, 1'b1, -1);
    chk("tog.best_a", 64'(best_a), 64'd9);
    chk("tog.best_e", 64'(best_e), 64'd8000);

    sweep("restart", 2, 1'b0, 50);
    chk("restart.best_a", 64'(best_a), 64'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b1;
    audio = 24'sd500;
    step(8);
    chk("mid.busy", 64'(busy), 64'd1);
    rst = 1'b0;
    manual = 6'd6;
    step();
    chk_dly("mid_rst", 0, 0, 0, 0);
    chk("mid_rst.cur", 64'(cur), 64'd0);
    chk("mid_rst.best_a", 64'(best_a), 64'd0);
    chk("mid_rst.best_e", 64'(best_e), 64'd0);
    chk("mid_rst.busy", 64'(busy), 64'd0);
    chk("mid_rst.done", 64'(done), 64'd0);
    valid = 1'b0;
    audio = '0;
    step(2);
    rst = 1'b1;
    step();
    chk("rel.cur", 64'(cur), 64'd0);
    chk("rel.d1", 64'(d1), 64'd0);
    step(3);
    chk("rel.track", 64'(cur), 64'd6);
    chk_dly("rel", 6, 4, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
